// File: rtl/spi_rx_deser_if.sv
// spi_rx_deser_if: received-word valid/ready stream
interface spi_rx_deser_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI receive deserializer with registered valid/ready output, overrun and abort pulses
module spi_rx_deser #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck_rise,
  input  logic                 cs_n,
  input  logic                 miso,
  spi_rx_deser_if.master       rx,
  output logic                 overrun,
  output logic                 frame_abort,
  output logic                 frame_active,
  output logic [7:0]           word_cnt
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
  logic [0:0]        state;
  logic [DATA_W-1:0] sr, sr_base, sr_next;
  logic [CW-1:0]     bcnt, bcnt_base;
  logic [7:0]        wc_base;
  logic              start, sample, done, load;
  // a frame start clears the per-frame state in the same cycle it may sample bit 0
  always_comb begin
    start     = state == IDLE && !cs_n;
    sample    = !cs_n && sck_rise;
    sr_base   = start ? '0 : sr;
    bcnt_base = start ? '0 : bcnt;
    wc_base   = start ? '0 : word_cnt;
    sr_next   = MSB_FIRST ? {sr_base[DATA_W-2:0], miso} : {miso, sr_base[DATA_W-1:1]};
    done      = sample && bcnt_base == CW'(DATA_W - 1);
    load      = done && (!rx.rx_valid || rx.rx_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      bcnt        <= '0;
      word_cnt    <= '0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
    end else begin
      state       <= cs_n ? IDLE : SHIFT;
      frame_abort <= state == SHIFT && cs_n && bcnt != '0;
      overrun     <= done && rx.rx_valid && !rx.rx_ready;
      bcnt        <= cs_n ? '0 : !sample ? bcnt_base : done ? '0 : bcnt_base + CW'(1);
      sr          <= cs_n ? sr : sample ? sr_next : sr_base;
      word_cnt    <= done ? (wc_base == 8'hFF ? wc_base : wc_base + 8'd1) : wc_base;
      rx.rx_valid <= load || (rx.rx_valid && !rx.rx_ready);
      if (load) rx.rx_data <= sr_next;
    end
  end
  assign frame_active = state == SHIFT;
endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: MSB- and LSB-first instances against a bit-queue reference model
module tb_spi_rx_deser;
  logic clk = 1'b0, rst = 1'b1, sck_rise = 1'b0, cs_n = 1'b1, miso = 1'b0, rx_ready = 1'b0;
  logic ovr_m, ab_m, act_m, ovr_l, ab_l, act_l;
  logic [7:0] wc_m, wc_l;
  int n_chk = 0, n_err = 0;
  spi_rx_deser_if #(.DATA_W(8)) rx_m ();
  spi_rx_deser_if #(.DATA_W(8)) rx_l ();
  assign rx_m.rx_ready = rx_ready;
  assign rx_l.rx_ready = rx_ready;
  spi_rx_deser #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sck_rise(sck_rise), .cs_n(cs_n), .miso(miso), .rx(rx_m),
    .overrun(ovr_m), .frame_abort(ab_m), .frame_active(act_m), .word_cnt(wc_m));
  spi_rx_deser #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sck_rise(sck_rise), .cs_n(cs_n), .miso(miso), .rx(rx_l),
    .overrun(ovr_l), .frame_abort(ab_l), .frame_active(act_l), .word_cnt(wc_l));
  always #5 clk = ~clk;
  bit         bits[$];
  logic [7:0] m_data_m = '0, m_data_l = '0;
  bit         m_valid = 0, m_ovr = 0, m_abort = 0, m_act = 0;
  int         m_wc = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference: bits of the current frame are queued; a full queue becomes a word
  task automatic model_edge();
    bit acc, ld;
    logic [7:0] wm, wl;
    m_ovr = 0; m_abort = 0; ld = 0;
    if (rst) begin
      m_data_m = '0; m_data_l = '0; m_valid = 0; m_act = 0; m_wc = 0;
      bits.delete();
      return;
    end
    acc = m_valid && rx_ready;
    if (cs_n) begin
      m_abort = m_act && bits.size() != 0;
      m_act = 0;
      bits.delete();
    end else begin
      if (!m_act) begin
        m_act = 1; m_wc = 0; bits.delete();
      end
      if (sck_rise) begin
        bits.push_back(miso);
        if (bits.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = bits[i];
            wl[i]   = bits[i];
          end
          bits.delete();
          m_wc = m_wc < 255 ? m_wc + 1 : 255;
          if (!m_valid || acc) begin
            m_data_m = wm; m_data_l = wl; ld = 1;
          end else m_ovr = 1;
        end
      end
    end
    m_valid = ld ? 1'b1 : (m_valid && !acc);
  endtask
  task automatic step(input logic c, input logic s, input logic m, input logic r);
    cs_n = c; sck_rise = s; miso = m; rx_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid_m", rx_m.rx_valid, m_valid);
    chk("valid_l", rx_l.rx_valid, m_valid);
    chk("data_m", rx_m.rx_data, m_data_m);
    chk("data_l", rx_l.rx_data, m_data_l);
    chk("ovr_m", ovr_m, m_ovr);
    chk("ovr_l", ovr_l, m_ovr);
    chk("abort_m", ab_m, m_abort);
    chk("abort_l", ab_l, m_abort);
    chk("active_m", act_m, m_act);
    chk("active_l", act_l, m_act);
    chk("wc_m", wc_m, m_wc);
    chk("wc_l", wc_l, m_wc);
  endtask
  // sends a byte first-bit-first from bit 7; last_rdy applies on the final strobe
  task automatic send(input logic [7:0] b, input logic rdy, input logic last_rdy, input int gap);
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b1, b[i], i == 0 ? last_rdy : rdy);
      for (int g = 0; g < gap && i > 0; g++) step(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask
  logic c_rand;
  initial begin
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_valid", rx_m.rx_valid, 1'b0);
    chk("rst_active", act_m, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send(8'hA5, 1'b1, 1'b1, 0);
    chk("a5_data", rx_m.rx_data, 8'hA5);
    chk("a5_valid", rx_m.rx_valid, 1'b1);
    chk("a5_wc", wc_m, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_drop", rx_m.rx_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h80, 1'b1, 1'b1, 0);
    chk("lsb_01", rx_l.rx_data, 8'h01);
    chk("msb_80", rx_m.rx_data, 8'h80);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h3C, 1'b1, 1'b1, 1);
    chk("lsb_3c", rx_l.rx_data, 8'h3C);
    send(8'hC3, 1'b1, 1'b1, 1);
    chk("lsb_c3", rx_l.rx_data, 8'hC3);
    chk("lsb_wc2", wc_l, 8'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h11, 1'b0, 1'b0, 0);
    send(8'h22, 1'b0, 1'b0, 0);
    chk("ovr_hold", rx_m.rx_data, 8'h11);
    chk("ovr_pulse", ovr_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drop", rx_m.rx_valid, 1'b0);
    chk("ovr_once", ovr_m, 1'b0);
    send(8'h55, 1'b0, 1'b0, 0);
    send(8'hAA, 1'b0, 1'b1, 0);
    chk("same_data", rx_m.rx_data, 8'hAA);
    chk("same_valid", rx_m.rx_valid, 1'b1);
    chk("same_ovr", ovr_m, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_pulse", ab_m, 1'b1);
    chk("abort_novalid", rx_m.rx_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_once", ab_m, 1'b0);
    send(8'hF0, 1'b1, 1'b1, 0);
    chk("f0_data", rx_m.rx_data, 8'hF0);
    chk("f0_wc", wc_m, 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("noise_active", act_m, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_active", act_m, 1'b0);
    chk("rst_mid_wc", wc_m, 8'd0);
    rst = 1'b0;
    send(8'h81, 1'b1, 1'b1, 0);
    chk("r81_data", rx_m.rx_data, 8'h81);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256 * 8; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1);
    chk("wc_sat", wc_m, 8'd255);
    c_rand = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(199) == 0;
      if ($urandom_range(24) == 0) c_rand = ~c_rand;
      step(c_rand, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
